// File: rtl/data_mover_bram_mc.sv
// BRAM-to-BRAM data mover: copies a block from BRAM0 to BRAM1 through a fixed-latency
// register line, or fills a BRAM1 block with a constant. One element per cycle.
module data_mover_bram_mc #(
    parameter int CNT_BIT    = 31,
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 12,
    parameter int CORE_DELAY = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic               i_abort,
    input  logic               i_mode,
    input  logic [AWIDTH-1:0]  i_src_base,
    input  logic [AWIDTH-1:0]  i_dst_base,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic [DWIDTH-1:0]  i_fill_data,
    output logic               o_idle,
    output logic               o_read,
    output logic               o_write,
    output logic               o_done,
    output logic [AWIDTH-1:0]  addr_b0,
    output logic               ce_b0,
    output logic               we_b0,
    input  logic [DWIDTH-1:0]  q_b0,
    output logic [DWIDTH-1:0]  d_b0,
    output logic [AWIDTH-1:0]  addr_b1,
    output logic               ce_b1,
    output logic               we_b1,
    input  logic [DWIDTH-1:0]  q_b1,
    output logic [DWIDTH-1:0]  d_b1
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // The BRAM1 write register is the last stage of the line, so only CORE_DELAY-1 live here.
    localparam int NSTG = CORE_DELAY - 1;

    state_t             state_q, state_d;
    logic [CNT_BIT-1:0] num_q, num_d;
    logic [CNT_BIT-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_BIT-1:0] wr_cnt_q, wr_cnt_d;
    logic               mode_q, mode_d;
    logic [AWIDTH-1:0]  src_q, src_d;
    logic [AWIDTH-1:0]  dst_q, dst_d;
    logic [DWIDTH-1:0]  fill_q, fill_d;
    logic               ce_b0_q, ce_b0_d;
    logic [AWIDTH-1:0]  addr_b0_q, addr_b0_d;
    logic               wr_q, wr_d;
    logic [AWIDTH-1:0]  addr_b1_q, addr_b1_d;
    logic [DWIDTH-1:0]  d_b1_q, d_b1_d;
    logic               rd_vld_q, rd_vld_d;
    logic [DWIDTH-1:0]  dl_data_q [NSTG];
    logic [DWIDTH-1:0]  dl_data_d [NSTG];
    logic [NSTG-1:0]    dl_vld_q, dl_vld_d;
    logic               unused_q_b1;

    assign unused_q_b1 = ^q_b1;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        fill_d    = fill_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q + CNT_BIT'(wr_q);
        ce_b0_d   = 1'b0;
        addr_b0_d = addr_b0_q;
        wr_d      = 1'b0;
        addr_b1_d = addr_b1_q;
        d_b1_d    = d_b1_q;
        // q_b0 is valid the cycle after the strobe; rd_vld_q marks that cycle.
        rd_vld_d     = ce_b0_q;
        dl_data_d[0] = q_b0;
        dl_vld_d[0]  = rd_vld_q;
        for (int j = 1; j < NSTG; j++) begin
            dl_data_d[j] = dl_data_q[j-1];
            dl_vld_d[j]  = dl_vld_q[j-1];
        end

        if (dl_vld_q[NSTG-1]) begin
            wr_d      = 1'b1;
            addr_b1_d = dst_q + AWIDTH'(wr_cnt_d);
            d_b1_d    = dl_data_q[NSTG-1];
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    num_d    = i_num_cnt;
                    mode_d   = i_mode;
                    src_d    = i_src_base;
                    dst_d    = i_dst_base;
                    fill_d   = i_fill_data;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    if (i_num_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                        rd_cnt_d = CNT_BIT'(1);
                        if (i_mode) begin
                            wr_d      = 1'b1;
                            addr_b1_d = i_dst_base;
                            d_b1_d    = i_fill_data;
                        end else begin
                            ce_b0_d   = 1'b1;
                            addr_b0_d = i_src_base;
                        end
                    end
                end
            end
            S_RUN: begin
                if (rd_cnt_q == num_q) begin
                    state_d = mode_q ? S_DONE : S_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_BIT'(1);
                    if (mode_q) begin
                        wr_d      = 1'b1;
                        addr_b1_d = dst_q + AWIDTH'(rd_cnt_q);
                        d_b1_d    = fill_q;
                    end else begin
                        ce_b0_d   = 1'b1;
                        addr_b0_d = src_q + AWIDTH'(rd_cnt_q);
                    end
                end
            end
            S_DRAIN: begin
                if (wr_q && (wr_cnt_q == num_q - CNT_BIT'(1)))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over completion and discards everything in flight.
        if (i_abort && (state_q == S_RUN || state_q == S_DRAIN)) begin
            state_d   = S_IDLE;
            ce_b0_d   = 1'b0;
            wr_d      = 1'b0;
            rd_vld_d  = 1'b0;
            dl_vld_d  = '0;
            addr_b0_d = addr_b0_q;
            addr_b1_d = addr_b1_q;
            d_b1_d    = d_b1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            mode_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            fill_q    <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            ce_b0_q   <= 1'b0;
            addr_b0_q <= '0;
            wr_q      <= 1'b0;
            addr_b1_q <= '0;
            d_b1_q    <= '0;
            rd_vld_q  <= 1'b0;
            dl_vld_q  <= '0;
            for (int j = 0; j < NSTG; j++) dl_data_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            fill_q    <= fill_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            ce_b0_q   <= ce_b0_d;
            addr_b0_q <= addr_b0_d;
            wr_q      <= wr_d;
            addr_b1_q <= addr_b1_d;
            d_b1_q    <= d_b1_d;
            rd_vld_q  <= rd_vld_d;
            dl_vld_q  <= dl_vld_d;
            dl_data_q <= dl_data_d;
        end
    end

    assign o_idle  = (state_q == S_IDLE);
    assign o_done  = (state_q == S_DONE);
    assign o_read  = ce_b0_q;
    assign o_write = wr_q;
    assign addr_b0 = addr_b0_q;
    assign ce_b0   = ce_b0_q;
    assign we_b0   = 1'b0;
    assign d_b0    = '0;
    assign addr_b1 = addr_b1_q;
    assign ce_b1   = wr_q;
    assign we_b1   = wr_q;
    assign d_b1    = d_b1_q;

endmodule

// File: doc/data_mover_bram_mc.md
DATA_MOVER_BRAM_MC -- requirements
Module: data_mover_bram_mc

Interface
REQ-001 Parameters SHALL be: CNT_BIT, 31, transfer-count width; DWIDTH, 32, data width; AWIDTH, 12, BRAM address width; CORE_DELAY, 5, processing pipeline depth in cycles (legal >= 2).
REQ-002 Ports SHALL be, clock and reset first: clk in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-003 i_run in 1 start request; i_abort in 1 cancel request; i_mode in 1 0=copy b0->b1, 1=fill b1 with constant.
REQ-004 i_src_base in AWIDTH b0 start address; i_dst_base in AWIDTH b1 start address; i_num_cnt in CNT_BIT element count; i_fill_data in DWIDTH fill value.
REQ-005 o_idle out 1 FSM in IDLE; o_read out 1 read issued this cycle; o_write out 1 write issued this cycle; o_done out 1 completion pulse.
REQ-006 addr_b0 out AWIDTH; ce_b0 out 1; we_b0 out 1; q_b0 in DWIDTH; d_b0 out DWIDTH -- BRAM0 port, read-only use.
REQ-007 addr_b1 out AWIDTH; ce_b1 out 1; we_b1 out 1; q_b1 in DWIDTH (unused); d_b1 out DWIDTH -- BRAM1 port, write-only use.
REQ-008 The block SHALL use one clock, clk; reset_n SHALL be asynchronous and active-low.

Function
REQ-009 Single FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-010 IDLE: i_run=1 SHALL latch i_num_cnt, i_mode, i_src_base, i_dst_base, i_fill_data; next state RUN, or DONE if i_num_cnt==0.
REQ-011 i_run outside IDLE SHALL be ignored; latched config SHALL NOT change until next IDLE start.
REQ-012 RUN SHALL issue exactly one element per cycle, element k (0..N-1) in the k-th RUN cycle.
REQ-013 Copy mode, element k: ce_b0=1, we_b0=0, addr_b0=(src_base+k) mod 2^AWIDTH.
REQ-014 Copy mode: q_b0 SHALL be sampled one cycle after the read strobe and passed through a CORE_DELAY-stage register line of data plus valid.
REQ-015 Copy mode: write of element k SHALL occur exactly CORE_DELAY+1 cycles after its read strobe: ce_b1=we_b1=1, addr_b1=(dst_base+k) mod 2^AWIDTH, d_b1=q_b0 data of element k.
REQ-016 Fill mode: ce_b0 SHALL stay 0; element k written in its RUN cycle with d_b1=latched fill value, addr_b1 as REQ-015.
REQ-017 RUN exit: after the N-th issue, next state SHALL be DRAIN (copy) or DONE (fill).
REQ-018 DRAIN: SHALL remain until the N-th write has been issued; the cycle after it, state SHALL be DONE.
REQ-019 DONE SHALL last exactly one cycle with o_done=1, then IDLE.
REQ-020 Address arithmetic SHALL wrap modulo 2^AWIDTH without error; element counters SHALL be CNT_BIT wide.
REQ-021 Write counter SHALL increment only on we_b1=1; read counter only on issue in RUN.
REQ-022 i_abort=1 in RUN or DRAIN SHALL, next cycle: state IDLE, all delay-line valids cleared, no further reads/writes, o_done not pulsed; abort SHALL take priority over completion in the same cycle.
REQ-023 i_abort in IDLE or DONE SHALL have no effect.
REQ-024 o_read SHALL equal ce_b0; o_write SHALL equal we_b1; o_idle=1 iff state IDLE; we_b0=0 and d_b0=0 always.
REQ-025 When ce_b1=0, addr_b1 and d_b1 SHALL hold last value; when ce_b0=0, addr_b0 SHALL hold last value.

Reset
REQ-026 reset_n low SHALL immediately force state IDLE, counters 0, latched config 0, delay line data/valid 0.
REQ-027 During and after reset: o_idle=1; o_read, o_write, o_done, ce_b0, we_b0, ce_b1, we_b1=0; addr_b0, addr_b1, d_b0, d_b1=0.
REQ-028 Reset asserted mid-transfer SHALL suppress all pending writes; no write SHALL appear after reset release without a new i_run.

Verification
REQ-029 Copy, N=8, src=0x010, dst=0x100, CORE_DELAY=5, b0[i]=i+0xA0 -> reads cycles 1..8 after start, writes 7..14 cycles after start, b1[0x100..0x107]=0xA0..0xA7, single o_done pulse.
REQ-030 Fill, N=4, dst=0xFFE, fill=0xDEADBEEF -> writes to 0xFFE,0xFFF,0x000,0x001 on consecutive cycles, ce_b0 never high, o_done one cycle after last write.
REQ-031 N=0 start -> no ce_b0/ce_b1 activity, DONE one cycle after i_run, o_done pulse, back to IDLE.
REQ-032 Copy N=16, i_abort at 3rd cycle of DRAIN -> no writes after abort cycle, o_done never pulsed, o_idle=1 next cycle; new i_run then completes normally.
REQ-033 i_run held high throughout a copy N=5 -> only one transfer runs; second transfer starts only from IDLE after o_done.
REQ-034 reset_n pulsed low mid-RUN -> all outputs at REQ-027 values asynchronously, no stray we_b1 after release.
